// File: rtl/gt_cap_pkg.sv
// Shared types and widths for the GT RX capture block.
package gt_cap_pkg;

  localparam int unsigned GT_DATA_W = 192;
  localparam int unsigned GT_LANE_W = 32;
  localparam int unsigned GT_LANES  = GT_DATA_W / GT_LANE_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/gt_cap_ram.sv
// Simple dual-port capture RAM: port A write, port B registered read-first.
module gt_cap_ram
  import gt_cap_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = GT_DATA_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

  // Port A: write the captured word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Port B: registered read; a same-address write lands after this read.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/gt_rx_capture.sv
// Snapshots the GT RX stream into on-chip RAM and reads it back one lane at a time.
// Optional trigger ports and armed-state matching: define GT_RX_CAPTURE_TRIG_EN.
module gt_rx_capture
  import gt_cap_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = GT_DATA_W,
  parameter int unsigned LANE_W = GT_LANE_W
) (
  input  logic              gt_clk,
  input  logic              gt_rst,
  input  logic [DATA_W-1:0] gt_rx_data,
  input  logic              gt_rx_valid,
  input  logic              cap_start,
  input  logic              cap_reset,
  input  logic [ADDR_W-1:0] cap_len,
`ifdef GT_RX_CAPTURE_TRIG_EN
  input  logic [31:0]       trig_pattern,
  input  logic [31:0]       trig_mask,
`endif
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [2:0]        rd_idx,
  output logic [LANE_W-1:0] rd_data,
  output logic              cap_busy,
  output logic              cap_done,
  output logic [ADDR_W:0]   cap_count
);

  localparam int unsigned LANES = DATA_W / LANE_W;

  cap_state_t        state, state_next;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              wr_last;
  logic              start_ok;
  logic              trig_hit;
  logic [DATA_W-1:0] ram_q;
  logic [2:0]        rd_idx_q;
  logic              rd_vld_q;

  assign start_ok = cap_start && ((state == IDLE) || (state == DONE));
  assign wr_last  = (wr_addr == len_q);

`ifdef GT_RX_CAPTURE_TRIG_EN
  assign trig_hit = gt_rx_valid && (((gt_rx_data[31:0] ^ trig_pattern) & trig_mask) == '0);
`else
  assign trig_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge gt_clk) begin
    if (gt_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; cap_reset overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (cap_start) state_next = ARMED;
      end
      ARMED: begin
`ifdef GT_RX_CAPTURE_TRIG_EN
        if (trig_hit) state_next = (len_q == '0) ? DONE : CAPTURE;
`else
        state_next = CAPTURE;
`endif
      end
      CAPTURE: begin
        if (gt_rx_valid && wr_last) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
    if (cap_reset) state_next = IDLE;
  end

  // Status outputs and RAM write strobe.
  always_comb begin
    cap_busy = (state == ARMED) || (state == CAPTURE);
    cap_done = (state == DONE);
    wr_en    = 1'b0;
    case (state)
      ARMED:   wr_en = trig_hit;
      CAPTURE: wr_en = gt_rx_valid;
      default: wr_en = 1'b0;
    endcase
    if (cap_reset) wr_en = 1'b0;
  end

  // Capture datapath: latched length, write pointer, stored-word count.
  always_ff @(posedge gt_clk) begin
    if (gt_rst || cap_reset) begin
      len_q     <= '0;
      wr_addr   <= '0;
      cap_count <= '0;
    end else if (start_ok) begin
      len_q     <= cap_len;
      wr_addr   <= '0;
      cap_count <= '0;
    end else if (wr_en) begin
      cap_count <= cap_count + (ADDR_W + 1)'(1);
      // Pointer holds on the final word so a full-depth capture never wraps.
      if (!wr_last) wr_addr <= wr_addr + ADDR_W'(1);
    end
  end

  gt_cap_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (gt_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (gt_rx_data),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  // Lane select tracks the RAM read register; rd_vld_q forces zero out of reset.
  always_ff @(posedge gt_clk) begin
    if (gt_rst) begin
      rd_idx_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_idx_q <= rd_idx;
      rd_vld_q <= 1'b1;
    end
  end

  // Lane mux; unused lane selects read as zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (rd_vld_q && (rd_idx_q == 3'(i))) rd_data = ram_q[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: tb/tb_gt_rx_capture.sv
// Scenario bench for gt_rx_capture; expected words queue up as they are driven.
module tb_gt_rx_capture;
  import gt_cap_pkg::*;

  localparam int unsigned ADDR_W = 8;

`ifdef GT_RX_CAPTURE_TRIG_EN
  localparam bit ARM_JUNK = 1'b0;
`else
  localparam bit ARM_JUNK = 1'b1;
`endif

  logic              gt_clk = 1'b0;
  logic              gt_rst;
  logic [191:0]      gt_rx_data;
  logic              gt_rx_valid;
  logic              cap_start;
  logic              cap_reset;
  logic [ADDR_W-1:0] cap_len;
  logic [31:0]       trig_pattern;
  logic [31:0]       trig_mask;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        rd_idx;
  logic [31:0]       rd_data;
  logic              cap_busy;
  logic              cap_done;
  logic [ADDR_W:0]   cap_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [191:0] exp_q[$];

  always #5 gt_clk = ~gt_clk;

  gt_rx_capture #(
    .ADDR_W (ADDR_W),
    .DATA_W (192),
    .LANE_W (32)
  ) dut (
    .gt_clk       (gt_clk),
    .gt_rst       (gt_rst),
    .gt_rx_data   (gt_rx_data),
    .gt_rx_valid  (gt_rx_valid),
    .cap_start    (cap_start),
    .cap_reset    (cap_reset),
    .cap_len      (cap_len),
`ifdef GT_RX_CAPTURE_TRIG_EN
    .trig_pattern (trig_pattern),
    .trig_mask    (trig_mask),
`endif
    .rd_addr      (rd_addr),
    .rd_idx       (rd_idx),
    .rd_data      (rd_data),
    .cap_busy     (cap_busy),
    .cap_done     (cap_done),
    .cap_count    (cap_count)
  );

  function automatic logic [191:0] mk_word(input logic [7:0] tag, input logic [7:0] w);
    logic [191:0] r;
    for (int k = 0; k < 6; k++) r[k*32 +: 32] = {tag, w, 16'(k)};
    return r;
  endfunction

  task automatic tick();
    @(posedge gt_clk);
    #1;
  endtask

  task automatic arm(input logic [7:0] len);
    cap_len   = len;
    cap_start = 1'b1;
    tick();
    cap_start   = 1'b0;
    gt_rx_valid = ARM_JUNK;
    gt_rx_data  = mk_word(8'hEE, 8'hEE);
    tick();
    gt_rx_valid = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] tag, input logic [7:0] w);
    gt_rx_data  = mk_word(tag, w);
    gt_rx_valid = 1'b1;
    exp_q.push_back(gt_rx_data);
    tick();
    gt_rx_valid = 1'b0;
  endtask

  task automatic check_status(input string name, input logic busy, input logic done,
                              input logic [ADDR_W:0] cnt);
    n_cmp++;
    if (cap_busy !== busy || cap_done !== done || cap_count !== cnt) begin
      n_err++;
      $display("FAIL %s: busy/done/count got %b/%b/%0d want %b/%b/%0d",
               name, cap_busy, cap_done, cap_count, busy, done, cnt);
    end
  endtask

  task automatic read_back(input string name, input int n);
    logic [191:0] w;
    logic [31:0]  want;
    n_cmp++;
    if (exp_q.size() != n) begin
      n_err++;
      $display("FAIL %s_qsize: got %0d want %0d", name, exp_q.size(), n);
    end
    for (int a = 0; a < n; a++) begin
      if (exp_q.size() == 0) break;
      w = exp_q.pop_front();
      for (int idx = 0; idx < 8; idx++) begin
        rd_addr = ADDR_W'(a);
        rd_idx  = 3'(idx);
        tick();
        want = (idx < 6) ? w[idx*32 +: 32] : 32'h0;
        n_cmp++;
        if (rd_data !== want) begin
          n_err++;
          $display("FAIL %s_rd(%0d,%0d): got %h want %h", name, a, idx, rd_data, want);
        end
      end
    end
  endtask

  task automatic test_reset();
    gt_rst = 1'b1; gt_rx_data = '0; gt_rx_valid = 1'b0; cap_start = 1'b0; cap_reset = 1'b0;
    cap_len = '0; trig_pattern = '0; trig_mask = '0; rd_addr = '0; rd_idx = '0;
    repeat (3) tick();
    check_status("reset", 1'b0, 1'b0, '0);
    n_cmp++;
    if (rd_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rd: got %h want 00000000", rd_data);
    end
    gt_rst = 1'b0;
    tick();
    check_status("reset_rel", 1'b0, 1'b0, '0);
  endtask

  task automatic test_capture();
    arm(8'd3);
    check_status("cap_armed", 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) push_word(8'h00, 8'(i));
    check_status("cap_3", 1'b1, 1'b0, 9'd3);
    push_word(8'h00, 8'd3);
    check_status("cap_done", 1'b0, 1'b1, 9'd4);
    rd_addr = 8'd2; rd_idx = 3'd5;
    tick();
    n_cmp++;
    if (rd_data !== 32'h0002_0005) begin
      n_err++;
      $display("FAIL cap_rd25: got %h want 00020005", rd_data);
    end
    rd_idx = 3'd6;
    tick();
    n_cmp++;
    if (rd_data !== 32'h0) begin
      n_err++;
      $display("FAIL cap_rd26: got %h want 00000000", rd_data);
    end
    read_back("cap", 4);
  endtask

  task automatic test_stall();
    arm(8'd7);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        push_word(8'h30, 8'(i / 2));
      end else begin
        gt_rx_data  = mk_word(8'hBD, 8'(i));
        gt_rx_valid = 1'b0;
        tick();
      end
      if (i < 14) check_status("stall_run", 1'b1, 1'b0, 9'((i / 2) + 1));
      else        check_status("stall_done", 1'b0, 1'b1, 9'd8);
    end
    read_back("stall", 8);
  endtask

  task automatic test_abort();
    arm(8'd7);
    push_word(8'h40, 8'd0);
    push_word(8'h40, 8'd1);
    check_status("abort_pre", 1'b1, 1'b0, 9'd2);
    cap_reset = 1'b1;
    tick();
    cap_reset = 1'b0;
    check_status("abort_idle", 1'b0, 1'b0, '0);
    exp_q.delete();
    cap_start = 1'b1; cap_reset = 1'b1;
    tick();
    cap_start = 1'b0; cap_reset = 1'b0;
    check_status("abort_both", 1'b0, 1'b0, '0);
    arm(8'd1);
    rd_addr = 8'd0; rd_idx = 3'd0;
    push_word(8'h50, 8'd0);
    n_cmp++;
    if (rd_data !== 32'h4000_0000) begin
      n_err++;
      $display("FAIL abort_rdfirst: got %h want 40000000", rd_data);
    end
    push_word(8'h50, 8'd1);
    check_status("abort_restart", 1'b0, 1'b1, 9'd2);
    read_back("abort", 2);
  endtask

  task automatic test_busy_start();
    arm(8'd3);
    push_word(8'h55, 8'd0);
    cap_start = 1'b1; cap_len = 8'd0;
    push_word(8'h55, 8'd1);
    cap_start = 1'b0; cap_len = 8'd1;
    push_word(8'h55, 8'd2);
    check_status("busy_3", 1'b1, 1'b0, 9'd3);
    push_word(8'h55, 8'd3);
    check_status("busy_done", 1'b0, 1'b1, 9'd4);
    read_back("busy", 4);
  endtask

  task automatic test_full();
    arm(8'd255);
    for (int i = 0; i < 255; i++) push_word(8'h60, 8'(i));
    check_status("full_255", 1'b1, 1'b0, 9'd255);
    push_word(8'h60, 8'd255);
    check_status("full_done", 1'b0, 1'b1, 9'd256);
    read_back("full", 256);
  endtask

`ifdef GT_RX_CAPTURE_TRIG_EN
  task automatic test_trigger();
    logic [191:0] w;
    trig_mask = 32'hFFFF_FFFF; trig_pattern = 32'hA5A5_0001; cap_len = 8'd1;
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      gt_rx_data = mk_word(8'h70, 8'(c)); gt_rx_valid = 1'b1;
      tick();
      check_status("trig_wait", 1'b1, 1'b0, '0);
    end
    w = mk_word(8'h70, 8'd5);
    w[31:0] = 32'hA5A5_0001;
    gt_rx_data = w;
    exp_q.push_back(w);
    tick();
    gt_rx_valid = 1'b0;
    check_status("trig_hit", 1'b1, 1'b0, 9'd1);
    tick();
    push_word(8'h70, 8'd6);
    check_status("trig_done", 1'b0, 1'b1, 9'd2);
    read_back("trig", 2);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_capture();
    test_stall();
    test_abort();
    test_busy_start();
    test_full();
`ifdef GT_RX_CAPTURE_TRIG_EN
    test_trigger();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
